// File: rtl/axis_tap.sv
// AXI4-Stream tap: copies handshaked beats of a monitored bus onto m_axis,
// truncating or dropping frames under backpressure instead of stalling the tap.
module axis_tap #(
    parameter int DATA_WIDTH  = 8,
    parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter bit ID_ENABLE   = 1'b0,
    parameter int ID_WIDTH    = 8,
    parameter bit DEST_ENABLE = 1'b0,
    parameter int DEST_WIDTH  = 8,
    parameter bit USER_ENABLE = 1'b1,
    parameter int USER_WIDTH  = 1,
    parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = 1'b1,
    parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_MASK  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [DATA_WIDTH-1:0] tap_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] tap_axis_tkeep,
    input  logic                  tap_axis_tvalid,
    input  logic                  tap_axis_tready,
    input  logic                  tap_axis_tlast,
    input  logic [ID_WIDTH-1:0]   tap_axis_tid,
    input  logic [DEST_WIDTH-1:0] tap_axis_tdest,
    input  logic [USER_WIDTH-1:0] tap_axis_tuser,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [ID_WIDTH-1:0]   m_axis_tid,
    output logic [DEST_WIDTH-1:0] m_axis_tdest,
    output logic [USER_WIDTH-1:0] m_axis_tuser
);

    localparam int BW = DATA_WIDTH + KEEP_WIDTH + ID_WIDTH + DEST_WIDTH + USER_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        TRANSFER,
        TRUNCATE,
        WAIT
    } state_e;

    state_e state_q, state_d;
    logic   frame_q, frame_d;

    logic [ID_WIDTH-1:0]   last_id_q;
    logic [DEST_WIDTH-1:0] last_dest_q;

    logic          tap_beat;
    logic          fwd, trunc;
    logic [BW-1:0] int_beat;
    logic          int_tvalid;
    logic          int_ready_q, int_ready_d;

    logic [BW-1:0] out_q, tmp_q;
    logic          out_valid_q, out_valid_d;
    logic          tmp_valid_q, tmp_valid_d;
    logic          int_to_out, int_to_tmp, tmp_to_out;

    assign tap_beat = tap_axis_tvalid && tap_axis_tready;

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        fwd     = 1'b0;
        trunc   = 1'b0;
        if (tap_beat) begin
            frame_d = !tap_axis_tlast;
        end
        unique case (state_q)
            IDLE: begin
                if (tap_beat) begin
                    if (int_ready_q) begin
                        fwd     = 1'b1;
                        state_d = tap_axis_tlast ? IDLE : TRANSFER;
                    end else begin
                        state_d = tap_axis_tlast ? IDLE : WAIT;
                    end
                end
            end
            TRANSFER: begin
                if (tap_beat) begin
                    if (int_ready_q) begin
                        fwd = 1'b1;
                        if (tap_axis_tlast) begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = TRUNCATE;
                    end
                end
            end
            TRUNCATE: begin
                if (int_ready_q) begin
                    trunc   = 1'b1;
                    state_d = frame_d ? WAIT : IDLE;
                end
            end
            WAIT: begin
                if (tap_beat && tap_axis_tlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Terminating beat closes a truncated frame with the bad-frame marking
    always_comb begin
        int_beat   = '0;
        int_tvalid = fwd || trunc;
        if (fwd) begin
            int_beat = {tap_axis_tdata, tap_axis_tkeep, tap_axis_tid,
                        tap_axis_tdest, tap_axis_tuser, tap_axis_tlast};
        end else if (trunc) begin
            int_beat = {{DATA_WIDTH{1'b0}}, KEEP_WIDTH'(1), last_id_q, last_dest_q,
                        (USER_WIDTH'(0) & ~USER_BAD_FRAME_MASK) |
                        (USER_BAD_FRAME_VALUE & USER_BAD_FRAME_MASK),
                        1'b1};
        end
    end

    assign int_ready_d = m_axis_tready ||
                         (!tmp_valid_q && (!out_valid_q || !int_tvalid));

    always_comb begin
        out_valid_d = out_valid_q;
        tmp_valid_d = tmp_valid_q;
        int_to_out  = 1'b0;
        int_to_tmp  = 1'b0;
        tmp_to_out  = 1'b0;
        if (int_ready_q) begin
            if (m_axis_tready || !out_valid_q) begin
                out_valid_d = int_tvalid;
                int_to_out  = 1'b1;
            end else begin
                tmp_valid_d = int_tvalid;
                int_to_tmp  = 1'b1;
            end
        end else if (m_axis_tready) begin
            out_valid_d = tmp_valid_q;
            tmp_valid_d = 1'b0;
            tmp_to_out  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            frame_q     <= 1'b0;
            out_valid_q <= 1'b0;
            tmp_valid_q <= 1'b0;
            int_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            out_valid_q <= out_valid_d;
            tmp_valid_q <= tmp_valid_d;
            int_ready_q <= int_ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fwd) begin
            last_id_q   <= tap_axis_tid;
            last_dest_q <= tap_axis_tdest;
        end
        if (int_to_out) begin
            out_q <= int_beat;
        end else if (tmp_to_out) begin
            out_q <= tmp_q;
        end
        if (int_to_tmp) begin
            tmp_q <= int_beat;
        end
    end

    logic [DATA_WIDTH-1:0] o_data;
    logic [KEEP_WIDTH-1:0] o_keep;
    logic [ID_WIDTH-1:0]   o_id;
    logic [DEST_WIDTH-1:0] o_dest;
    logic [USER_WIDTH-1:0] o_user;
    logic                  o_last;

    assign {o_data, o_keep, o_id, o_dest, o_user, o_last} = out_q;

    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tdata  = o_data;
    assign m_axis_tlast  = o_last;
    assign m_axis_tkeep  = KEEP_ENABLE ? o_keep : {KEEP_WIDTH{1'b1}};
    assign m_axis_tid    = ID_ENABLE ? o_id : '0;
    assign m_axis_tdest  = DEST_ENABLE ? o_dest : '0;
    assign m_axis_tuser  = USER_ENABLE ? o_user : '0;

endmodule

// File: tb/tb_axis_tap.sv
// Scoreboard bench for axis_tap: frame-level reference model feeds an expected
// queue; an independent monitor checks every beat leaving m_axis.
module tb_axis_tap;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic [7:0]  id;
        logic [7:0]  dest;
        logic        user;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] tdata = '0;
    logic [7:0]  tkeep = '0;
    logic [7:0]  tid = '0;
    logic [7:0]  tdest = '0;
    logic        tuser = 1'b0;
    logic        tv = 1'b0;
    logic        tr = 1'b0;
    logic        tl = 1'b0;
    logic        mtr = 1'b0;

    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic [7:0]  m_tid;
    logic [7:0]  m_tdest;
    logic [0:0]  m_tuser;
    logic        m_tvalid;
    logic        m_tlast;

    always #5 clk = ~clk;

    axis_tap #(
        .DATA_WIDTH(64),
        .KEEP_ENABLE(1'b1),
        .KEEP_WIDTH(8),
        .ID_ENABLE(1'b1),
        .ID_WIDTH(8),
        .DEST_ENABLE(1'b1),
        .DEST_WIDTH(8),
        .USER_ENABLE(1'b1),
        .USER_WIDTH(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tap_axis_tdata(tdata),
        .tap_axis_tkeep(tkeep),
        .tap_axis_tvalid(tv),
        .tap_axis_tready(tr),
        .tap_axis_tlast(tl),
        .tap_axis_tid(tid),
        .tap_axis_tdest(tdest),
        .tap_axis_tuser(tuser),
        .m_axis_tdata(m_tdata),
        .m_axis_tkeep(m_tkeep),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(mtr),
        .m_axis_tlast(m_tlast),
        .m_axis_tid(m_tid),
        .m_axis_tdest(m_tdest),
        .m_axis_tuser(m_tuser)
    );

    int    vectors = 0;
    int    errors = 0;
    int    out_beats = 0;
    beat_t exp_q[$];

    // Reference model: buffer occupancy plus frame-level flags
    int          occ;
    bit          rdy, fwd_mode, drop_mode, trunc_pend, frame_open;
    logic [7:0]  last_id, last_dest;

    beat_t cur;
    assign cur = '{data: m_tdata, keep: m_tkeep, id: m_tid, dest: m_tdest,
                   user: m_tuser[0], last: m_tlast};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_clear();
        occ = 0;
        rdy = 0;
        fwd_mode = 0;
        drop_mode = 0;
        trunc_pend = 0;
        frame_open = 0;
        exp_q.delete();
    endtask

    task automatic model_step();
        beat_t b;
        bit    beat, push, pop, fo_next;
        b = '0;
        push = 0;
        chk("m_tvalid_timing", {63'd0, m_tvalid}, {63'd0, occ != 0});
        beat = tv && tr;
        fo_next = beat ? !tl : frame_open;
        if (trunc_pend) begin
            if (rdy) begin
                b.keep = 8'h01;
                b.id = last_id;
                b.dest = last_dest;
                b.user = 1'b1;
                b.last = 1'b1;
                push = 1;
                trunc_pend = 0;
                drop_mode = fo_next;
            end
        end else if (drop_mode) begin
            if (beat && tl) drop_mode = 0;
        end else if (beat) begin
            if (rdy) begin
                b = '{data: tdata, keep: tkeep, id: tid, dest: tdest, user: tuser, last: tl};
                push = 1;
                last_id = tid;
                last_dest = tdest;
                fwd_mode = !tl;
            end else if (fwd_mode) begin
                fwd_mode = 0;
                trunc_pend = 1;
            end else begin
                drop_mode = !tl;
            end
        end
        frame_open = fo_next;
        pop = mtr && (occ > 0);
        rdy = mtr || (occ == 0) || (occ == 1 && !push);
        occ = occ + int'(push) - int'(pop);
        if (push) exp_q.push_back(b);
    endtask

    // Inputs are set just after a rising edge; the model steps at the falling edge
    task automatic step();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [63:0] d, input logic [7:0] k, input logic [7:0] i,
                            input logic [7:0] de, input logic u, input logic last);
        tdata = d;
        tkeep = k;
        tid = i;
        tdest = de;
        tuser = u;
        tl = last;
        tv = 1'b1;
        tr = 1'b1;
    endtask

    task automatic rand_beat(input logic last);
        set_beat({$urandom, $urandom}, 8'($urandom), 8'($urandom), 8'($urandom),
                 1'($urandom), last);
    endtask

    task automatic idle(input int n);
        tv = 1'b0;
        tr = 1'b0;
        tl = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_frame(input int n);
        for (int i = 0; i < n; i++) begin
            rand_beat(i == n - 1);
            step();
        end
        tv = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tv = 1'b0;
        tr = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic rand_phase(input int n, input int ptv, input int ptr, input int pmr);
        for (int i = 0; i < n; i++) begin
            rand_beat($urandom_range(3) == 0);
            tv = ($urandom_range(99) < ptv);
            tr = ($urandom_range(99) < ptr);
            mtr = ($urandom_range(99) < pmr);
            step();
        end
    endtask

    // Monitor: in-order compare of every m_axis handshake, plus hold stability
    bit    hold = 0;
    beat_t held;
    always @(negedge clk) begin
        if (rst) begin
            hold = 0;
        end else begin
            if (hold) begin
                chk("hold_valid", {63'd0, m_tvalid}, 64'd1);
                chk("hold_data", cur.data, held.data);
                chk("hold_ctrl", 64'(cur[25:0]), 64'(held[25:0]));
            end
            if (m_tvalid && mtr) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h, expected none at %0t", cur.data, $time);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_data", cur.data, e.data);
                    chk("beat_ctrl", 64'(cur[25:0]), 64'(e[25:0]));
                end
                out_beats++;
            end
            hold = m_tvalid && !mtr;
            held = cur;
        end
    end

    int base;

    initial begin
        model_clear();
        last_id = '0;
        last_dest = '0;
        do_reset();
        chk("reset_tvalid", {63'd0, m_tvalid}, 64'd0);
        mtr = 1'b1;
        idle(2);

        // 3-beat 64-bit frame with fixed contents, sink always ready
        base = out_beats;
        set_beat(64'h0807060504030201, 8'hFF, 8'd1, 8'd2, 1'b0, 1'b0);
        step();
        set_beat(64'h100F0E0D0C0B0A09, 8'hFF, 8'd1, 8'd2, 1'b0, 1'b0);
        step();
        set_beat(64'h1817161514131211, 8'hFF, 8'd1, 8'd2, 1'b0, 1'b1);
        step();
        idle(4);
        chk("frame3_count", 64'(out_beats - base), 64'd3);

        // Sink stalled across a 4-beat frame: two beats plus terminator
        base = out_beats;
        mtr = 1'b0;
        send_frame(4);
        idle(3);
        mtr = 1'b1;
        idle(6);
        chk("trunc_count", 64'(out_beats - base), 64'd3);

        // Output full before frame start: frame dropped, next passes
        base = out_beats;
        mtr = 1'b0;
        send_frame(1);
        send_frame(1);
        send_frame(2);
        idle(2);
        mtr = 1'b1;
        idle(3);
        send_frame(3);
        idle(4);
        chk("drop_count", 64'(out_beats - base), 64'd5);

        // tap_axis_tready toggling with tvalid held
        base = out_beats;
        for (int i = 0; i < 6; i++) begin
            rand_beat(i == 4);
            tr = (i % 2 == 0);
            step();
        end
        idle(4);
        chk("toggle_count", 64'(out_beats - base), 64'd3);

        // Back-to-back single-beat frames
        base = out_beats;
        for (int i = 0; i < 5; i++) begin
            rand_beat(1'b1);
            step();
        end
        idle(4);
        chk("b2b_count", 64'(out_beats - base), 64'd5);

        // Asynchronous reset while a beat is held on the output
        mtr = 1'b0;
        send_frame(1);
        idle(1);
        chk("pre_reset_valid", {63'd0, m_tvalid}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_valid", {63'd0, m_tvalid}, 64'd0);
        do_reset();
        mtr = 1'b1;
        idle(2);
        base = out_beats;
        send_frame(3);
        idle(4);
        chk("post_reset_count", 64'(out_beats - base), 64'd3);

        // Reset in the middle of a tapped frame
        send_frame(2);
        rand_beat(1'b0);
        step();
        do_reset();
        rand_beat(1'b1);
        step();
        idle(2);

        rand_phase(1500, 70, 70, 100);
        rand_phase(1500, 70, 70, 50);
        rand_phase(1500, 90, 90, 20);
        rand_phase(1500, 50, 80, 80);

        mtr = 1'b1;
        idle(10);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/axis_tap.md
AXIS_TAP -- requirements
Module: axis_tap

Interface
REQ-001 DATA_WIDTH, default 8: tdata width in bits.
REQ-002 KEEP_ENABLE, default (DATA_WIDTH>8): tkeep used; when 0, m_axis_tkeep SHALL be all ones.
REQ-003 KEEP_WIDTH, default DATA_WIDTH/8: tkeep width.
REQ-004 ID_ENABLE, default 0 / ID_WIDTH, default 8: tid used / width; when disabled, m_axis_tid SHALL be 0.
REQ-005 DEST_ENABLE, default 0 / DEST_WIDTH, default 8: tdest used / width; when disabled, m_axis_tdest SHALL be 0.
REQ-006 USER_ENABLE, default 1 / USER_WIDTH, default 1: tuser used / width; when disabled, m_axis_tuser SHALL be 0.
REQ-007 USER_BAD_FRAME_VALUE, default 1'b1 / USER_BAD_FRAME_MASK, default 1'b1: tuser marking for truncated frames.
REQ-008 clk  in  1  sole clock; all state on rising edge.
REQ-009 rst  in  1  asynchronous, active-high reset.
REQ-010 tap_axis_tdata/tkeep/tid/tdest/tuser  in  DATA_WIDTH/KEEP_WIDTH/ID_WIDTH/DEST_WIDTH/USER_WIDTH  monitored stream fields.
REQ-011 tap_axis_tvalid, tap_axis_tready, tap_axis_tlast  in  1 each  monitored handshake; the block SHALL never drive the tapped bus.
REQ-012 m_axis_tdata/tkeep/tid/tdest/tuser  out  same widths  copied stream.
REQ-013 m_axis_tvalid, m_axis_tlast  out  1 each; m_axis_tready  in  1.

Function
REQ-014 A tap beat SHALL occur only in a cycle where tap_axis_tvalid and tap_axis_tready are both 1.
REQ-015 Output path SHALL be a registered two-entry skid buffer (output register plus temp register); internal ready = m_axis_tready OR (temp empty AND (output empty OR no internal beat)), registered.
REQ-016 An accepted beat SHALL appear on m_axis, all fields unchanged, on the cycle after the tap beat; no beat is duplicated or reordered.
REQ-017 FSM states: IDLE, TRANSFER, TRUNCATE, WAIT.
REQ-018 IDLE, tap beat, internal ready=1: forward; tlast -> IDLE, else -> TRANSFER.
REQ-019 IDLE, tap beat, internal ready=0: drop the beat; tlast -> IDLE, else -> WAIT (whole frame dropped).
REQ-020 TRANSFER, tap beat, internal ready=1: forward; tlast -> IDLE.
REQ-021 TRANSFER, tap beat, internal ready=0: drop the beat -> TRUNCATE.
REQ-022 TRUNCATE: when internal ready=1, emit one terminating beat: tdata 0, tkeep only bit 0 set, tlast 1, tid/tdest of the last forwarded beat, tuser = (0 & ~MASK) | (VALUE & MASK); then -> IDLE if the tapped frame's tlast has already passed, else -> WAIT.
REQ-023 A frame_reg flag SHALL track an open tapped frame: set on a non-last tap beat, cleared on a tlast beat, in every state.
REQ-024 WAIT: drop all tap beats; on a tap beat with tlast -> IDLE.
REQ-025 Tapped frames SHALL never block the tapped bus; output backpressure SHALL only truncate or drop frames.
REQ-026 Every frame emitted on m_axis SHALL end with tlast; a truncated frame SHALL carry the bad-frame tuser only on its last beat.
REQ-027 m_axis_tvalid, once high, SHALL hold with stable fields until m_axis_tready=1.

Reset
REQ-028 On rst=1, immediately and asynchronously: state IDLE, frame_reg 0, output and temp valid 0, m_axis_tvalid 0, internal ready 0; data registers need not be reset.
REQ-029 Reset mid-frame SHALL discard any partial frame; after release, tap beats until the next frame start are treated as a new frame.

Verification
REQ-030 m_axis_tready=1, 64-bit, 3-beat frame 0x01..0x18, tid=1, tdest=2, tuser=0 -> identical 3 beats on m_axis, each 1 cycle later, last with tlast.
REQ-031 m_axis_tready=0 throughout a 4-beat frame -> at most the first 2 beats buffered, then one beat tkeep=0x01 tlast=1 tuser=1; remaining tap beats dropped.
REQ-032 Output already full at frame start, 2-beat frame -> nothing emitted for that frame; next frame with m_axis_tready=1 passes intact.
REQ-033 tap_axis_tready toggling 1/0 with tvalid=1 -> only handshaked beats forwarded, no duplicates.
REQ-034 Assert rst mid-frame with m_axis_tvalid=1 -> m_axis_tvalid=0 without waiting for a clock edge; next full frame passes intact.
REQ-035 Back-to-back single-beat frames, m_axis_tready=1 -> one output beat per cycle, each tlast=1.
